stream_mux_rr: RTL and testbench

Parametrised N-channel registered stream multiplexer with valid/ready handshakes. It selects one input channel per transfer, either by a fixed select (`sel`) or by round-robin arbitration. It presents the chosen beat from a single output register that is held under backpressure. It replaces the combinational 8:1 select in datapaths that need flow control, fairness and a defined idle output instead of X.

---
 rtl/stream_mux_pkg.sv | 12 +
 rtl/stream_mux_rr_arbiter.sv | 34 +++
 rtl/stream_mux_rr.sv | 145 ++++++++++++++
 tb/tb_stream_mux_rr.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream_mux_rr registered stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } mux_state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotate-priority encoder: first request strictly after ptr, wrapping,
// returned as a one-hot grant and its index.
module rr_arbiter #(
    parameter int N_CH  = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] idx
);

    logic              found;
    int unsigned       pos;
    logic [SEL_W-1:0]  pos_s;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        pos_s = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            pos   = (32'(ptr) + i) % N_CH;
            pos_s = SEL_W'(pos);
            if (!found && req[pos_s]) begin
                found        = 1'b1;
                grant[pos_s] = 1'b1;
                idx          = pos_s;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with fixed-select or round-robin arbitration.
// Optional packet lock (in_last/out_last) is enabled by defining STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [N_CH-1:0]       in_last,
    output logic                  out_last,
`endif
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic              load;
    logic              transfer;
    logic              locked;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  cand;
    logic              cand_ok;
    logic              cand_valid;
    logic              cand_last;
    logic [WIDTH-1:0]  cand_data;
    logic [N_CH-1:0]   rr_grant;
    logic [SEL_W-1:0]  rr_idx;

`ifdef STREAM_MUX_PKT_LOCK_EN
    mux_state_t        state;
    logic [SEL_W-1:0]  lock_ch;
    assign locked = (state == LOCK);
`else
    assign locked = 1'b0;
`endif

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    always_comb begin
        load       = en & (~out_valid | out_ready);
        cand       = '0;
        cand_ok    = 1'b0;
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        cand_data  = '0;
        in_ready   = '0;

`ifdef STREAM_MUX_PKT_LOCK_EN
        if (locked) begin
            cand    = lock_ch;
            cand_ok = 1'b1;
        end else
`endif
        if (mode == MODE_RR) begin
            cand    = rr_idx;
            cand_ok = |rr_grant;
        end else begin
            cand    = sel;
            cand_ok = ({1'b0, sel} < (SEL_W+1)'(N_CH));
        end

        // Decode by loop so an out-of-range sel never indexes past the buses.
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (SEL_W'(k) == cand) begin
                cand_valid = in_valid[k];
                cand_data  = in_data[k*WIDTH +: WIDTH];
`ifdef STREAM_MUX_PKT_LOCK_EN
                cand_last  = in_last[k];
`endif
            end
        end

        transfer = load & cand_ok & cand_valid;

        for (int unsigned k = 0; k < N_CH; k++) begin
            in_ready[k] = transfer && (SEL_W'(k) == cand);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SEL_W'(N_CH - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last  <= 1'b0;
            state     <= IDLE;
            lock_ch   <= '0;
`endif
        end else begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= cand_data;
                out_ch    <= cand;
                if (!locked && mode == MODE_RR) begin
                    ptr <= cand;
                end
`ifdef STREAM_MUX_PKT_LOCK_EN
                out_last <= cand_last;
                case (state)
                    IDLE: begin
                        if (!cand_last) begin
                            state   <= LOCK;
                            lock_ch <= cand;
                        end
                    end
                    LOCK: begin
                        if (cand_last) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // cand_last is only consumed by the packet-lock path.
    logic unused_ok;
    assign unused_ok = cand_last;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr (N_CH=8, WIDTH=8).
module tb_stream_mux_rr;

    localparam int N_CH  = 8;
    localparam int WIDTH = 8;
    localparam int SEL_W = 3;
    localparam logic [7:0] DATA [8] = '{8'hC0, 8'hB1, 8'hA2, 8'hA5, 8'hC4, 8'hD5, 8'hE6, 8'hF7};

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [N_CH-1:0]       in_last;
    logic                  out_last;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int k = 0; k < N_CH; k++) in_data[k*WIDTH +: WIDTH] = DATA[k];
`ifdef STREAM_MUX_PKT_LOCK_EN
        in_last = '0;
`endif
        repeat (2) tick();
        rst = 1'b0;
        en  = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_out_valid", out_valid, 0);
            check("idle_out_data", out_data, 0);
            check("idle_in_ready", in_ready, 0);
        end

        // Fixed mode, sel=3
        mode      = 1'b0;
        sel       = 3'd3;
        out_ready = 1'b1;
        in_valid  = 8'h20;
        #1 check("fix_sel_not_valid", in_ready, 8'h00);
        in_valid  = 8'h28;
        #1 check("fix_in_ready", in_ready, 8'h08);
        tick();
        check("fix_out_valid", out_valid, 1);
        check("fix_out_data", out_data, 8'hA5);
        check("fix_out_ch", out_ch, 3);
        in_valid = '0;
        tick();
        check("fix_drain_valid", out_valid, 0);
        check("fix_drain_hold", out_data, 8'hA5);

        // Round robin, all valid: 0..7 then 0
        reset_dut();
        mode     = 1'b1;
        in_valid = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            #1 check("rr_in_ready", in_ready, 64'(8'h01 << (i % 8)));
            tick();
            check("rr_out_ch", out_ch, i % 8);
            check("rr_out_data", out_data, DATA[i % 8]);
            check("rr_out_valid", out_valid, 1);
        end

        // Backpressure after first beat
        reset_dut();
        tick();
        check("bp_first_ch", out_ch, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_in_ready", in_ready, 0);
            tick();
            check("bp_hold_ch", out_ch, 0);
            check("bp_hold_data", out_data, 8'hC0);
            check("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 8'h02);
        tick();
        check("bp_next_ch", out_ch, 1);

        // en dropped while output full
        en        = 1'b0;
        out_ready = 1'b0;
        #1 check("en_off_ready", in_ready, 0);
        tick();
        check("en_off_held", out_valid, 1);
        check("en_off_held_ch", out_ch, 1);
        out_ready = 1'b1;
        #1 check("en_off_drain_ready", in_ready, 0);
        tick();
        check("en_off_drained", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_off_no_grant", out_valid, 0);
            check("en_off_no_ready", in_ready, 0);
        end

        // Asynchronous reset mid-beat
        en = 1'b1;
        tick();
        check("ar_beat_valid", out_valid, 1);
        check("ar_beat_ch", out_ch, 2);
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_cleared_valid", out_valid, 0);
        check("ar_cleared_data", out_data, 0);
        check("ar_cleared_ch", out_ch, 0);
        #1 rst = 1'b0;
        tick();
        check("ar_post_first_ch", out_ch, 0);
        check("ar_post_valid", out_valid, 1);

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Channel 2 sends a 3-beat packet while channel 5 waits
        reset_dut();
        mode      = 1'b1;
        out_ready = 1'b1;
        in_valid  = 8'h24;
        in_last   = 8'h20;
        for (int b = 0; b < 3; b++) begin
            in_last[2] = (b == 2);
            #1 check("lock_in_ready", in_ready, 8'h04);
            tick();
            check("lock_out_ch", out_ch, 2);
            check("lock_out_last", out_last, (b == 2));
        end
        in_valid = 8'h20;
        #1 check("lock_release_ready", in_ready, 8'h20);
        tick();
        check("lock_after_ch", out_ch, 5);
        check("lock_after_last", out_last, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
